// File: rtl/sysid_boot_checker.sv
// Boot-time check of the system-ID slave: reads the ID and timestamp words over Avalon-MM,
// latches both, and reports pass/fail/timeout to the music-player boot sequencer and firmware.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h87654321,
  parameter logic [31:0] MIN_TIMESTAMP  = 32'd0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StRdId,
    StRdTs,
    StCheck,
    StFinish
  } state_e;

  state_e      r_state, w_state;
  logic        r_read, w_read;
  logic        r_addr, w_addr;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        r_id_ok, w_id_ok;
  logic        r_timeout, w_timeout;
  logic [31:0] r_id, w_id;
  logic [31:0] r_ts, w_ts;
  logic [15:0] r_stall, w_stall;
  logic [32:0] w_ts_diff;

  // Borrow-out of ts - MIN gives an unsigned >= without a constant-true compare when MIN is 0.
  assign w_ts_diff = {1'b0, r_ts} - {1'b0, MIN_TIMESTAMP};

  always_comb begin
    w_state   = r_state;
    w_read    = r_read;
    w_addr    = r_addr;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_id_ok   = r_id_ok;
    w_timeout = r_timeout;
    w_id      = r_id;
    w_ts      = r_ts;
    w_stall   = r_stall;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state   = StRdId;
          w_read    = 1'b1;
          w_addr    = 1'b0;
          w_busy    = 1'b1;
          w_id_ok   = 1'b0;
          w_timeout = 1'b0;
          w_stall   = '0;
        end
      end
      StRdId, StRdTs: begin
        // Timeout is tested before the handshake, so a grant on the limit cycle is still an abort.
        if (r_stall == TimeoutLimit) begin
          w_timeout = 1'b1;
          w_read    = 1'b0;
          w_addr    = 1'b0;
          w_busy    = 1'b0;
          w_done    = 1'b1;
          w_state   = StFinish;
        end else if (!avm_waitrequest) begin
          w_stall = '0;
          if (r_state == StRdId) begin
            w_id    = avm_readdata;
            w_addr  = 1'b1;
            w_state = StRdTs;
          end else begin
            w_ts    = avm_readdata;
            w_read  = 1'b0;
            w_addr  = 1'b0;
            w_state = StCheck;
          end
        end else if (r_stall != 16'hFFFF) begin
          w_stall = r_stall + 16'd1;
        end
      end
      StCheck: begin
        w_id_ok = (r_id == EXPECTED_ID) && !w_ts_diff[32];
        w_busy  = 1'b0;
        w_done  = 1'b1;
        w_state = StFinish;
      end
      StFinish: w_state = StIdle;
      default:  w_state = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_read    <= 1'b0;
      r_addr    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_id_ok   <= 1'b0;
      r_timeout <= 1'b0;
      r_id      <= '0;
      r_ts      <= '0;
      r_stall   <= '0;
    end else begin
      r_state   <= w_state;
      r_read    <= w_read;
      r_addr    <= w_addr;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_id_ok   <= w_id_ok;
      r_timeout <= w_timeout;
      r_id      <= w_id;
      r_ts      <= w_ts;
      r_stall   <= w_stall;
    end
  end

  assign avm_read    = r_read;
  assign avm_address = r_addr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign id_ok       = r_id_ok;
  assign timeout_err = r_timeout;
  assign id_value    = r_id;
  assign ts_value    = r_ts;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench: two checker instances (default and tight MIN/timeout) against a stalling slave.
module tb_sysid_boot_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  start_s, rd_s, addr_s, wr_s, busy_s, done_s, ok_s, to_s, stuck;
  logic [31:0] rdata [2];
  logic [31:0] idv [2];
  logic [31:0] tsv [2];
  logic [31:0] id_word [2];
  logic [31:0] ts_word [2];
  int          stall_n [2];
  int          checks = 0;
  int          errors = 0;

  sysid_boot_checker u_a (
    .clock(clk), .reset_n(rst_n), .start(start_s[0]), .avm_address(addr_s[0]),
    .avm_read(rd_s[0]), .avm_waitrequest(wr_s[0]), .avm_readdata(rdata[0]),
    .busy(busy_s[0]), .done(done_s[0]), .id_ok(ok_s[0]), .timeout_err(to_s[0]),
    .id_value(idv[0]), .ts_value(tsv[0])
  );

  sysid_boot_checker #(
    .MIN_TIMESTAMP(32'h70000000),
    .TIMEOUT_CYCLES(4)
  ) u_b (
    .clock(clk), .reset_n(rst_n), .start(start_s[1]), .avm_address(addr_s[1]),
    .avm_read(rd_s[1]), .avm_waitrequest(wr_s[1]), .avm_readdata(rdata[1]),
    .busy(busy_s[1]), .done(done_s[1]), .id_ok(ok_s[1]), .timeout_err(to_s[1]),
    .id_value(idv[1]), .ts_value(tsv[1])
  );

  // Slave: stalls each read stall_n cycles (or forever when stuck), then returns the word.
  for (genvar g = 0; g < 2; g++) begin : g_slv
    int scnt;
    assign wr_s[g]  = stuck[g] | (rd_s[g] & (scnt < stall_n[g]));
    assign rdata[g] = addr_s[g] ? ts_word[g] : id_word[g];
    always @(posedge clk) begin
      if (rd_s[g] && wr_s[g]) scnt <= scnt + 1;
      else scnt <= 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_run(input int inst, input logic [31:0] idw, input logic [31:0] tsw,
                        input int stalls, input logic stk, output int dcyc, output int npulse,
                        output logic stable, output int nacc, output logic [1:0] seq,
                        output logic rd_done);
    logic prd, pad, pwr;
    id_word[inst] = idw;
    ts_word[inst] = tsw;
    stall_n[inst] = stalls;
    stuck[inst]   = stk;
    @(negedge clk) start_s[inst] = 1'b1;
    @(negedge clk) start_s[inst] = 1'b0;
    dcyc = -1; npulse = 0; stable = 1'b1; nacc = 0; seq = 2'b00; rd_done = 1'b0;
    prd = 1'b0; pad = 1'b0; pwr = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (pwr && (rd_s[inst] !== prd || addr_s[inst] !== pad)) stable = 1'b0;
      if (rd_s[inst] && !wr_s[inst]) begin
        if (nacc < 2) seq[nacc] = addr_s[inst];
        nacc++;
      end
      if (done_s[inst]) begin
        npulse++;
        if (dcyc < 0) begin
          dcyc    = c;
          rd_done = rd_s[inst];
        end
      end
      prd = rd_s[inst]; pad = addr_s[inst]; pwr = rd_s[inst] & wr_s[inst];
      if (dcyc > 0 && c >= dcyc + 3) break;
      @(negedge clk);
    end
  endtask

  typedef struct {
    int          inst;
    logic [31:0] idw;
    logic [31:0] tsw;
    int          stalls;
    logic        exp_ok;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int          dcyc, npulse, nacc, cnt;
    logic        stable, rd_done;
    logic [1:0]  seq;
    vecs[0] = '{0, 32'h87654321, 32'h6950F917, 0, 1'b1, 4};
    vecs[1] = '{0, 32'h12345678, 32'h6950F917, 0, 1'b0, 4};
    vecs[2] = '{0, 32'h87654321, 32'h6950F917, 3, 1'b1, 10};
    vecs[3] = '{0, 32'h87654321, 32'h00000000, 1, 1'b1, 6};
    vecs[4] = '{0, 32'h87654320, 32'hFFFFFFFF, 2, 1'b0, 8};
    vecs[5] = '{1, 32'h87654321, 32'h6950F917, 0, 1'b0, 4};
    vecs[6] = '{1, 32'h87654321, 32'h70000000, 0, 1'b1, 4};
    vecs[7] = '{1, 32'h87654321, 32'h6FFFFFFF, 3, 1'b0, 10};

    rst_n = 1'b0; start_s = 2'b00; stuck = 2'b00;
    stall_n[0] = 0; stall_n[1] = 0;
    id_word[0] = '0; id_word[1] = '0; ts_word[0] = '0; ts_word[1] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_read", rd_s[0], 0);
    chk("rst_addr", addr_s[0], 0);
    chk("rst_busy", busy_s[0], 0);
    chk("rst_done", done_s[0], 0);
    chk("rst_id_ok", ok_s[0], 0);
    chk("rst_timeout", to_s[0], 0);
    chk("rst_id_value", idv[0], 0);
    chk("rst_ts_value", tsv[0], 0);

    for (int i = 0; i < 8; i++) begin
      do_run(vecs[i].inst, vecs[i].idw, vecs[i].tsw, vecs[i].stalls, 1'b0,
             dcyc, npulse, stable, nacc, seq, rd_done);
      chk($sformatf("v%0d_done_cycle", i), dcyc, vecs[i].exp_cyc);
      chk($sformatf("v%0d_done_pulses", i), npulse, 1);
      chk($sformatf("v%0d_stall_stable", i), stable, 1);
      chk($sformatf("v%0d_read_count", i), nacc, 2);
      chk($sformatf("v%0d_read_order", i), seq, 2'b10);
      chk($sformatf("v%0d_id_ok", i), ok_s[vecs[i].inst], vecs[i].exp_ok);
      chk($sformatf("v%0d_timeout", i), to_s[vecs[i].inst], 0);
      chk($sformatf("v%0d_id_value", i), idv[vecs[i].inst], vecs[i].idw);
      chk($sformatf("v%0d_ts_value", i), tsv[vecs[i].inst], vecs[i].tsw);
    end

    // Stuck slave: abort after 4 stalls, ID word must not be captured.
    do_run(1, 32'hDEADBEEF, 32'h70000000, 0, 1'b1, dcyc, npulse, stable, nacc, seq, rd_done);
    stuck[1] = 1'b0;
    chk("stuck_done_cycle", dcyc, 6);
    chk("stuck_done_pulses", npulse, 1);
    chk("stuck_timeout", to_s[1], 1);
    chk("stuck_id_ok", ok_s[1], 0);
    chk("stuck_read_at_done", rd_done, 0);
    chk("stuck_reads", nacc, 0);
    chk("stuck_id_value", idv[1], 32'h87654321);

    // Exactly TIMEOUT_CYCLES stalls then a grant: still a timeout.
    do_run(1, 32'h11111111, 32'h70000000, 4, 1'b0, dcyc, npulse, stable, nacc, seq, rd_done);
    chk("edge_done_cycle", dcyc, 6);
    chk("edge_timeout", to_s[1], 1);
    chk("edge_id_ok", ok_s[1], 0);
    chk("edge_id_value", idv[1], 32'h87654321);

    // Clean rerun clears the latched timeout.
    do_run(1, 32'h87654321, 32'h70000000, 0, 1'b0, dcyc, npulse, stable, nacc, seq, rd_done);
    chk("rerun_done_cycle", dcyc, 4);
    chk("rerun_timeout", to_s[1], 0);
    chk("rerun_id_ok", ok_s[1], 1);

    // Start while busy and coincident with done: one run only.
    id_word[0] = 32'h87654321; ts_word[0] = 32'h6950F917; stall_n[0] = 0;
    @(negedge clk) start_s[0] = 1'b1;
    @(negedge clk) start_s[0] = 1'b0;
    cnt = 0; dcyc = -1;
    for (int c = 1; c <= 15; c++) begin
      if (done_s[0]) begin
        cnt++;
        if (dcyc < 0) dcyc = c;
      end
      start_s[0] = (c == 2 || c == 4);
      @(negedge clk);
    end
    start_s[0] = 1'b0;
    chk("busy_start_pulses", cnt, 1);
    chk("busy_start_done_cycle", dcyc, 4);
    chk("busy_start_idle", busy_s[0], 0);
    chk("busy_start_read", rd_s[0], 0);

    // Reset during a stalled timestamp read.
    stall_n[0] = 3;
    @(negedge clk) start_s[0] = 1'b1;
    @(negedge clk) start_s[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_read", rd_s[0], 1);
    chk("pre_reset_addr", addr_s[0], 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_read", rd_s[0], 0);
    chk("mid_reset_addr", addr_s[0], 0);
    chk("mid_reset_busy", busy_s[0], 0);
    chk("mid_reset_id_value", idv[0], 0);
    chk("mid_reset_ts_value", tsv[0], 0);
    chk("mid_reset_id_ok", ok_s[0], 0);
    @(negedge clk) rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (done_s[0] || rd_s[0]) cnt++;
      @(negedge clk);
    end
    chk("post_reset_quiet", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysid_boot_checker.md
Name: sysid_boot_checker

Overview:
- Avalon-MM master that sits directly upstream of the system-ID slave and consumes its two read-only words: word 0 is the system ID, word 1 is the generation timestamp.
- On a start pulse it reads both words, compares the ID against the expected build value and the timestamp against a minimum, then reports pass/fail.
- It gates the music-player boot sequence.
- It gives the Nios II firmware a latched, readable copy of both words.

Parameters:
- EXPECTED_ID, 32'h87654321, system ID value that constitutes a pass.
- MIN_TIMESTAMP, 32'd0, timestamp must be >= this value (unsigned) to pass.
- TIMEOUT_CYCLES, 255, maximum waitrequest stall cycles per read before abort; range 1..65535.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to run a check; ignored while busy.
- avm_address  out  1  word select: 0 = ID, 1 = timestamp.
- avm_read  out  1  read strobe.
- avm_waitrequest  in  1  slave stall; tie 0 for a zero-wait slave.
- avm_readdata  in  32  read data; valid in the cycle avm_read=1 and avm_waitrequest=0.
- busy  out  1  check in progress.
- done  out  1  single-cycle pulse at completion (pass, fail or timeout).
- id_ok  out  1  latched result: 1 = ID match and timestamp OK.
- timeout_err  out  1  latched: a read exceeded TIMEOUT_CYCLES.
- id_value  out  32  latched system ID word.
- ts_value  out  32  latched timestamp word.

Behaviour:
- Reset (async assert, synchronous-release domain): state=IDLE; avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, timeout_err=0, id_value=0, ts_value=0, stall counter=0.
- States: IDLE, RD_ID, RD_TS, CHECK, FINISH.
- IDLE:
  - start=1 -> RD_ID next cycle.
  - On this transition: clear id_ok, timeout_err and stall counter; set busy=1.
  - id_value and ts_value keep their old contents until overwritten.
- RD_ID:
  - avm_read=1, avm_address=0, both registered.
  - In the cycle waitrequest=0: capture readdata into id_value, clear the stall counter, go to RD_TS.
  - While waitrequest=1: increment the stall counter.
  - Counter reaches TIMEOUT_CYCLES: set timeout_err=1, drop avm_read, go to FINISH.
- RD_TS: same as RD_ID with avm_address=1; capture into ts_value; on success go to CHECK.
- CHECK (one cycle, avm_read=0): id_ok <= (id_value==EXPECTED_ID) && (ts_value>=MIN_TIMESTAMP), unsigned 32-bit compare.
- FINISH: done=1 for exactly one cycle, busy=0, then IDLE.
- Latency with a zero-wait slave: start sampled at cycle 0; reads at cycles 1 and 2; CHECK at cycle 3; done at cycle 4.
- Avalon rules:
  - avm_read and avm_address stay stable while waitrequest=1.
  - No back-to-back gap is required between the two reads.
  - avm_read never asserts outside RD_ID/RD_TS.
- Boundary conditions:
  - start while busy: ignored, no queueing.
  - start in the same cycle as done: ignored; a new run needs start in a later IDLE cycle.
  - TIMEOUT_CYCLES stalls then waitrequest=0 on the next cycle: counts as a timeout, because the check precedes the capture.
  - Timeout: id_ok=0. The captured word of the failed read is not updated.
  - reset_n low mid-read: all outputs return to reset values immediately; avm_read drops asynchronously.
  - Stall counter width: 16 bits, saturating, no wrap.

Test Plan:
- Zero-wait slave returning 0x87654321 / 0x6950F917, start pulse -> reads at address 0 then 1; done at cycle 4; id_ok=1, id_value=0x87654321, ts_value=0x6950F917, timeout_err=0.
- Slave returns ID 0x12345678 -> done pulse, id_ok=0, id_value=0x12345678.
- MIN_TIMESTAMP=0x70000000 with correct ID and ts 0x6950F917 -> id_ok=0. Rerun with ts 0x70000000 -> id_ok=1 (boundary equality).
- waitrequest held 3 cycles on each read -> address and read stable during stall; done at cycle 10; id_ok=1.
- TIMEOUT_CYCLES=4, waitrequest stuck high -> timeout_err=1, id_ok=0, avm_read=0 after abort, single done pulse.
- reset_n asserted during RD_TS, plus start pulsed while busy on a separate run -> immediate reset values; the busy-time start produces no second run and exactly one done pulse.
